// File: rtl/core_pkg.sv
// Shared core definitions: sequencer state encoding, datapath width,
// default reset/trap vectors and the instruction alignment mask.
package core_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  // Low address bits that must be zero for a legal 32-bit instruction target.
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the branch decision logic, the PC sequencer
// and the instruction memory address port.
interface pc_sequencer_if;
  import core_pkg::*;

  logic            stall;
  logic            br_taken;
  logic            jump;
  logic [XLEN-1:0] target;
  logic            trap_ack;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_en;
  logic            flush;
  logic            misalign_trap;
  logic [XLEN-1:0] trap_pc;

  // The sequencer owns the PC side of the bundle.
  modport master (
    input  stall, br_taken, jump, target, trap_ack,
    output pc, pc_plus4, fetch_en, flush, misalign_trap, trap_pc
  );

  modport slave (
    output stall, br_taken, jump, target, trap_ack,
    input  pc, pc_plus4, fetch_en, flush, misalign_trap, trap_pc
  );

endinterface

// File: rtl/pc_seq_perf.sv
// Saturating event counters for the PC sequencer (redirects, stalls, traps).
// Only instantiated when PC_SEQ_PERF_EN is defined.
module pc_seq_perf
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            redirect_ev,
  input  logic            stall_ev,
  input  logic            trap_ev,
  output logic [XLEN-1:0] redirect_cnt,
  output logic [XLEN-1:0] stall_cnt,
  output logic [15:0]     trap_cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_cnt <= '0;
      stall_cnt    <= '0;
      trap_cnt     <= '0;
    end else begin
      if (redirect_ev && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + 1'b1;
      if (stall_ev    && (stall_cnt    != '1)) stall_cnt    <= stall_cnt + 1'b1;
      if (trap_ev     && (trap_cnt     != '1)) trap_cnt     <= trap_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter and fetch sequencer: boot wait, redirect, stall and
// misaligned-target trap handling. Optional counters under PC_SEQ_PERF_EN.
module pc_sequencer
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
  parameter int unsigned     BOOT_CYCLES  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.master  bus
`ifdef PC_SEQ_PERF_EN
  ,
  output logic [XLEN-1:0] redirect_cnt,
  output logic [XLEN-1:0] stall_cnt,
  output logic [15:0]     trap_cnt
`endif
);

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  seq_state_e      state_q, state_d;
  logic [3:0]      boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic            fetch_en_q, fetch_en_d;
  logic            flush_q, flush_d;
  logic            trap_q, trap_d;

  logic redirect;
  logic misaligned;

  assign redirect   = bus.br_taken | bus.jump;
  assign misaligned = (bus.target[1:0] & ALIGN_MASK) != 2'b00;

  // NOTE: every next-state variable takes its hold value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    pc_d       = pc_q;
    trap_pc_d  = trap_pc_q;
    fetch_en_d = fetch_en_q;
    trap_d     = trap_q;
    flush_d    = 1'b0;

    unique case (state_q)
      BOOT: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BOOT_LAST) begin
          state_d    = RUN;
          fetch_en_d = 1'b1;
        end
      end
      RUN: begin
        if (redirect && misaligned) begin
          state_d    = TRAP;
          trap_pc_d  = bus.target;
          fetch_en_d = 1'b0;
          trap_d     = 1'b1;
        end else if (redirect) begin
          // A redirect wins over a simultaneous stall.
          pc_d    = bus.target;
          flush_d = 1'b1;
        end else if (!bus.stall) begin
          pc_d = pc_q + 32'd4;
        end
      end
      TRAP: begin
        if (bus.trap_ack) begin
          state_d    = RUN;
          pc_d       = TRAP_VECTOR;
          trap_d     = 1'b0;
          fetch_en_d = 1'b1;
          flush_d    = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      boot_cnt_q <= '0;
      pc_q       <= RESET_VECTOR;
      trap_pc_q  <= '0;
      fetch_en_q <= 1'b0;
      flush_q    <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      pc_q       <= pc_d;
      trap_pc_q  <= trap_pc_d;
      fetch_en_q <= fetch_en_d;
      flush_q    <= flush_d;
      trap_q     <= trap_d;
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_q + 32'd4;
  assign bus.fetch_en      = fetch_en_q;
  assign bus.flush         = flush_q;
  assign bus.misalign_trap = trap_q;
  assign bus.trap_pc       = trap_pc_q;

`ifdef PC_SEQ_PERF_EN
  logic in_run;
  assign in_run = (state_q == RUN);

  pc_seq_perf u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .redirect_ev  (in_run & redirect & ~misaligned),
    .stall_ev     (in_run & bus.stall & ~redirect),
    .trap_ev      (in_run & redirect & misaligned),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt),
    .trap_cnt     (trap_cnt)
  );
`endif

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Owns the program counter and sequences instruction fetch for the single-cycle RISC-V core.
- Consumes the branch/jump resolution (taken, jump, target) and applies redirect, stall, boot-wait and misaligned-target trap handling.
- Sits between the branch decision logic and the instruction memory address port. The branch unit's taken output drives br_taken directly.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded at reset.
- TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap acknowledge.
- BOOT_CYCLES, 4, fetch-disabled cycles after reset release (range 1..15).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold PC this cycle (memory/hazard wait)
- br_taken  in  1  conditional branch taken (branch && check)
- jump  in  1  jal/jalr resolved this cycle (always taken)
- target  in  32  branch/jump target address
- trap_ack  in  1  trap handler accepted the trap
- pc  out  32  current fetch address (registered)
- pc_plus4  out  32  pc + 4, combinational, wraps modulo 2^32
- fetch_en  out  1  instruction memory read enable (registered)
- flush  out  1  one-cycle pulse on the cycle after a redirect (registered)
- misalign_trap  out  1  high while in TRAP state
- trap_pc  out  32  offending target captured at trap entry

Behaviour:
- Reset (async, rst_n=0) sets pc=RESET_VECTOR, fetch_en=0, flush=0, misalign_trap=0, trap_pc=0, state=BOOT, boot_cnt=0. All other outputs derive from these.
- States are BOOT, RUN and TRAP.
- BOOT:
  - boot_cnt increments each cycle; all inputs are ignored; fetch_en=0.
  - When boot_cnt==BOOT_CYCLES-1, the next state is RUN and fetch_en is set to 1.
- RUN: redirect = br_taken | jump. Priority per cycle:
  1. redirect with target[1:0]!=0:
     - next state TRAP; trap_pc<=target; pc holds; fetch_en<=0; misalign_trap<=1.
  2. redirect with aligned target:
     - pc<=target and flush<=1 for exactly one cycle.
     - Redirect overrides stall. A simultaneous stall is dropped.
  3. stall: pc holds, flush<=0.
  4. otherwise: pc<=pc+4 (wraps from 32'hFFFF_FFFC to 0), flush<=0.
- Targets with target[1]=1 and target[0]=0 trap. No compressed-instruction support.
- TRAP:
  - pc holds and fetch_en=0; br_taken, jump and stall are ignored.
  - On trap_ack: pc<=TRAP_VECTOR, misalign_trap<=0, fetch_en<=1, flush<=1 for one cycle, next state RUN.
  - trap_pc holds its value until the next trap entry.
- Latency: redirect is visible on pc one cycle after the inputs are sampled. flush is asserted in that same cycle.
- trap_ack outside TRAP is ignored.
- Reset asserted mid-operation (any state) returns immediately to BOOT values. A pending flush or trap is discarded.

Optional Feature:
- Macro: PC_SEQ_PERF_EN.
- When defined, adds the following outputs, all reset to 0:
  - redirect_cnt[31:0]: counts aligned redirects taken in RUN.
  - stall_cnt[31:0]: counts RUN cycles where stall held the PC and no redirect occurred.
  - trap_cnt[15:0]: counts trap entries.
- All counters saturate at all-ones.
- When not defined, these ports and their registers do not exist, and the remaining behaviour is identical.

Decomposition:
- Shared package core_pkg holds:
  - the state enumeration (BOOT, RUN, TRAP, 2-bit encoding);
  - XLEN=32;
  - the default RESET_VECTOR and TRAP_VECTOR constants;
  - an ALIGN_MASK constant (2'b11).
- One natural sub-module, pc_seq_perf: the saturating counter bank, instantiated only under PC_SEQ_PERF_EN.
- The FSM and the PC register stay in pc_sequencer.

Test Plan:
- Reset and boot:
  - Stimulus: rst_n low, release, BOOT_CYCLES=4.
  - Response: pc=0 and fetch_en=0 for 4 cycles after release; then fetch_en=1 with pc sequencing 0,4,8,...
- Aligned branch:
  - Stimulus: in RUN at pc=0x20, br_taken=1, target=0x80 for one cycle.
  - Response: next cycle pc=0x80 with flush=1; following cycle pc=0x84 with flush=0.
- Stall versus jump:
  - Stimulus: at pc=0x40, stall=1 for 3 cycles, then stall=1 and jump=1 with target=0x200 together.
  - Response: pc holds 0x40 for 3 cycles, then pc=0x200 with flush=1.
- Misaligned trap:
  - Stimulus: jump=1, target=0x102; trap_ack asserted 5 cycles later.
  - Response during trap: misalign_trap=1, trap_pc=0x102, fetch_en=0, pc frozen.
  - Response after trap_ack: pc=0x100, flush=1, misalign_trap=0.
- Wrap and async reset:
  - Stimulus: pc reaches 0xFFFF_FFFC with no stall; later rst_n asserted mid-cycle while in TRAP.
  - Response: next pc=0x0; on reset, outputs immediately return to reset values and state is BOOT.
- PC_SEQ_PERF_EN:
  - Stimulus: 3 aligned redirects, 2 stall cycles, 1 trap.
  - Response: redirect_cnt=3, stall_cnt=2, trap_cnt=1.
